// File: rtl/sap_datapath.sv
// sap_datapath: execution end of the SAP machine. Holds PC, MAR, the 16x8
// program memory, IR, registers A-D, the adder, flags and the output
// register, and drives the shared bus from the sequencer's control word.
module sap_datapath #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [14:0]       control_lines,
   output logic [DATA_W-1:0] bus_out,
   output logic [3:0]        reg_ir,
   output logic [1:0]        flag_lines,
   output logic [DATA_W-1:0] out_port,
   output logic              out_valid,
   output logic              bus_conflict,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data
);

   logic ep, lm, cnt, li, em, la, lb, lc, ld, ea, eb, es, lo, ei, lp;
   assign ep  = control_lines[0];
   assign lm  = control_lines[1];
   assign cnt = control_lines[2];
   assign li  = control_lines[3];
   assign em  = control_lines[4];
   assign la  = control_lines[5];
   assign lb  = control_lines[6];
   assign lc  = control_lines[7];
   assign ld  = control_lines[8];
   assign ea  = control_lines[9];
   assign eb  = control_lines[10];
   assign es  = control_lines[11];
   assign lo  = control_lines[12];
   assign ei  = control_lines[13];
   assign lp  = control_lines[14];

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] reg_a;
   logic [DATA_W-1:0] reg_b;
   logic [DATA_W-1:0] reg_c;
   logic [DATA_W-1:0] reg_d;
   logic              carry;
   logic              zero;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W:0]   sum;
   logic [5:0]        enables;
   logic              multi_drive;

   // Adder is always live; carry is the ninth bit.
   assign sum = {1'b0, reg_a} + {1'b0, reg_b};

   // More than one bus enable set means some driver lost arbitration.
   assign enables     = {es, eb, ea, ei, em, ep};
   assign multi_drive = |(enables & (enables - 6'd1));

   assign reg_ir     = ir[DATA_W-1:DATA_W-4];
   assign flag_lines = {zero, carry};

   // Bus mux: fixed priority EP > EM > EI > EA > EB > ES, idle bus reads 0.
   always_comb begin
      bus_out = '0;
      if (ep)      bus_out = {{(DATA_W-ADDR_W){1'b0}}, pc};
      else if (em) bus_out = mem[mar];
      else if (ei) bus_out = {{(DATA_W-4){1'b0}}, ir[3:0]};
      else if (ea) bus_out = reg_a;
      else if (eb) bus_out = reg_b;
      else if (es) bus_out = sum[DATA_W-1:0];
   end

   // Program memory: no reset; reads above see the pre-edge contents.
   always_ff @(posedge clk) begin
      if (prog_we) mem[prog_addr] <= prog_data;
   end

   // Architectural registers load from the bus at the edge after the control word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc           <= '0;
         mar          <= '0;
         ir           <= '0;
         reg_a        <= '0;
         reg_b        <= '0;
         reg_c        <= '0;
         reg_d        <= '0;
         carry        <= 1'b0;
         zero         <= 1'b0;
         out_port     <= '0;
         out_valid    <= 1'b0;
         bus_conflict <= 1'b0;
      end else begin
         if (lp)       pc <= bus_out[ADDR_W-1:0];
         else if (cnt) pc <= pc + 1'b1;
         if (lm) mar   <= bus_out[ADDR_W-1:0];
         if (li) ir    <= bus_out;
         if (la) reg_a <= bus_out;
         if (lb) reg_b <= bus_out;
         if (lc) reg_c <= bus_out;
         if (ld) reg_d <= bus_out;
         // Flags track only an adder result written back into A.
         if (la && es) begin
            carry <= sum[DATA_W];
            zero  <= (sum[DATA_W-1:0] == '0);
         end
         if (lo) out_port <= bus_out;
         out_valid <= lo;
         if (multi_drive) bus_conflict <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath: directed vector table for the documented SAP sequences,
// a hand-written async-reset / read-before-write sequence, and a randomized
// run against a behavioural model of the datapath.
module tb_sap_datapath;

   localparam logic [14:0] M_EP = 15'h0001, M_LM = 15'h0002, M_C  = 15'h0004,
                           M_LI = 15'h0008, M_EM = 15'h0010, M_LA = 15'h0020,
                           M_LB = 15'h0040, M_LC = 15'h0080, M_LD = 15'h0100,
                           M_EA = 15'h0200, M_EB = 15'h0400, M_ES = 15'h0800,
                           M_LO = 15'h1000, M_EI = 15'h2000, M_LP = 15'h4000;

   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] control_lines;
   logic [7:0]  bus_out;
   logic [3:0]  reg_ir;
   logic [1:0]  flag_lines;
   logic [7:0]  out_port;
   logic        out_valid;
   logic        bus_conflict;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [7:0]  prog_data;

   int n_checks = 0;
   int n_pass   = 0;

   sap_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .control_lines(control_lines), .bus_out(bus_out),
      .reg_ir(reg_ir), .flag_lines(flag_lines), .out_port(out_port),
      .out_valid(out_valid), .bus_conflict(bus_conflict), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: whole-machine state as plain integers.
   int m_pc, m_mar, m_ir, m_a, m_b, m_c, m_d, m_out, m_vld, m_carry, m_zero, m_conf;
   int m_mem [16];

   function automatic int model_bus(input logic [14:0] cw);
      if (cw & M_EP) return m_pc;
      if (cw & M_EM) return m_mem[m_mar];
      if (cw & M_EI) return m_ir % 16;
      if (cw & M_EA) return m_a;
      if (cw & M_EB) return m_b;
      if (cw & M_ES) return (m_a + m_b) % 256;
      return 0;
   endfunction

   task automatic model_reset();
      m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_c = 0; m_d = 0;
      m_out = 0; m_vld = 0; m_carry = 0; m_zero = 0; m_conf = 0;
   endtask

   task automatic model_edge(input logic [14:0] cw, input logic pwe,
                             input int pa, input int pd);
      int bus, s, n_en;
      bus  = model_bus(cw);
      s    = m_a + m_b;
      n_en = 0;
      foreach (cw[i]) if (i inside {0, 4, 9, 10, 11, 13} && cw[i]) n_en++;
      if (n_en > 1) m_conf = 1;
      if ((cw & M_LA) && (cw & M_ES)) begin
         m_carry = (s > 255) ? 1 : 0;
         m_zero  = (s % 256 == 0) ? 1 : 0;
      end
      if (cw & M_LP)     m_pc = bus % 16;
      else if (cw & M_C) m_pc = (m_pc + 1) % 16;
      if (cw & M_LM) m_mar = bus % 16;
      if (cw & M_LI) m_ir  = bus;
      if (cw & M_LA) m_a   = bus;
      if (cw & M_LB) m_b   = bus;
      if (cw & M_LC) m_c   = bus;
      if (cw & M_LD) m_d   = bus;
      m_vld = (cw & M_LO) ? 1 : 0;
      if (cw & M_LO) m_out = bus;
      if (pwe) m_mem[pa] = pd;
   endtask

   // Called at posedge+1: drive, sample bus mid-cycle, cross the edge, return at posedge+1.
   task automatic cycle(input logic [14:0] cw, input logic pwe, input logic [3:0] pa,
                        input logic [7:0] pd, output logic [7:0] bus_seen);
      control_lines = cw;
      prog_we   = pwe;
      prog_addr = pa;
      prog_data = pd;
      #3;
      bus_seen = bus_out;
      @(posedge clk);
      #1;
      prog_we = 1'b0;
   endtask

   task automatic prog(input logic [3:0] pa, input logic [7:0] pd);
      logic [7:0] dummy;
      cycle(15'h0, 1'b1, pa, pd, dummy);
   endtask

   task automatic async_reset();
      control_lines = '0;
      #2 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string       name;
      logic [14:0] ctrl;
      logic [7:0]  bus;
      logic [3:0]  ir;
      logic [1:0]  flags;
      logic [7:0]  outp;
      logic        vld;
      logic        conf;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [7:0] b;
      logic [14:0] cw;
      logic pwe;
      logic [3:0] pa;
      logic [7:0] pd;

      tbl.push_back('{"fetch_ep_lm",  M_EP|M_LM,      8'h00, 4'h0, 2'b00, 8'h00, 1'b0, 1'b0});
      tbl.push_back('{"fetch_em_li",  M_C|M_LI|M_EM,  8'h1A, 4'h1, 2'b00, 8'h00, 1'b0, 1'b0});
      tbl.push_back('{"la_ei",        M_LA|M_EI,      8'h0A, 4'h1, 2'b00, 8'h00, 1'b0, 1'b0});
      tbl.push_back('{"lb_ea",        M_LB|M_EA,      8'h0A, 4'h1, 2'b00, 8'h00, 1'b0, 1'b0});
      tbl.push_back('{"add_14",       M_LA|M_ES,      8'h14, 4'h1, 2'b00, 8'h00, 1'b0, 1'b0});
      tbl.push_back('{"mar_1",        M_EP|M_LM,      8'h01, 4'h1, 2'b00, 8'h00, 1'b0, 1'b0});
      tbl.push_back('{"load_a_55",    M_EM|M_LA,      8'h55, 4'h1, 2'b00, 8'h00, 1'b0, 1'b0});
      tbl.push_back('{"out_55",       M_EA|M_LO,      8'h55, 4'h1, 2'b00, 8'h55, 1'b1, 1'b0});
      tbl.push_back('{"idle_out",     15'h0,          8'h00, 4'h1, 2'b00, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"inc_pc",       M_C,            8'h00, 4'h1, 2'b00, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"mar_2",        M_C|M_EP|M_LM,  8'h02, 4'h1, 2'b00, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"load_a_f0",    M_EM|M_LA,      8'hF0, 4'h1, 2'b00, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"mar_3",        M_EP|M_LM|M_C,  8'h03, 4'h1, 2'b00, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"load_b_10",    M_EM|M_LB,      8'h10, 4'h1, 2'b00, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"add_wrap",     M_LA|M_ES,      8'h00, 4'h1, 2'b11, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"flags_hold",   M_LB|M_EA,      8'h00, 4'h1, 2'b11, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"mar_4",        M_EP|M_LM|M_C,  8'h04, 4'h1, 2'b11, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"jump_15",      M_EM|M_LP,      8'h0F, 4'h1, 2'b11, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"pc15_wrap",    M_EP|M_C,       8'h0F, 4'h1, 2'b11, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"pc_is_0",      M_EP,           8'h00, 4'h1, 2'b11, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"mar_a",        M_EI|M_LM,      8'h0A, 4'h1, 2'b11, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"ir_e7",        M_EM|M_LI,      8'hE7, 4'hE, 2'b11, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"lp_wins",      M_EI|M_LP|M_C,  8'h07, 4'hE, 2'b11, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"pc_is_7",      M_EP,           8'h07, 4'hE, 2'b11, 8'h55, 1'b0, 1'b0});
      tbl.push_back('{"conflict",     M_EP|M_EA,      8'h07, 4'hE, 2'b11, 8'h55, 1'b0, 1'b1});
      tbl.push_back('{"conf_sticky",  15'h0,          8'h00, 4'hE, 2'b11, 8'h55, 1'b0, 1'b1});
      tbl.push_back('{"mar_7",        M_EP|M_LM,      8'h07, 4'hE, 2'b11, 8'h55, 1'b0, 1'b1});
      tbl.push_back('{"load_a_33",    M_EM|M_LA,      8'h33, 4'hE, 2'b11, 8'h55, 1'b0, 1'b1});
      tbl.push_back('{"pc_8",         M_C,            8'h00, 4'hE, 2'b11, 8'h55, 1'b0, 1'b1});
      tbl.push_back('{"pc_9",         M_C,            8'h00, 4'hE, 2'b11, 8'h55, 1'b0, 1'b1});

      rst = 1'b0;
      control_lines = '0;
      prog_we = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      @(posedge clk);
      #1;
      // Memory preload while held in reset; memory is not reset.
      prog(4'd0, 8'h1A);
      prog(4'd1, 8'h55);
      prog(4'd2, 8'hF0);
      prog(4'd3, 8'h10);
      prog(4'd4, 8'h0F);
      prog(4'd7, 8'h33);
      prog(4'd10, 8'hE7);

      chk("rst_bus",   bus_out,      8'h00);
      chk("rst_ir",    reg_ir,       4'h0);
      chk("rst_flags", flag_lines,   2'b00);
      chk("rst_out",   out_port,     8'h00);
      chk("rst_vld",   out_valid,    1'b0);
      chk("rst_conf",  bus_conflict, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         cycle(tbl[i].ctrl, 1'b0, 4'd0, 8'd0, b);
         chk({tbl[i].name, "_bus"},   b,            tbl[i].bus);
         chk({tbl[i].name, "_ir"},    reg_ir,       tbl[i].ir);
         chk({tbl[i].name, "_flags"}, flag_lines,   tbl[i].flags);
         chk({tbl[i].name, "_out"},   out_port,     tbl[i].outp);
         chk({tbl[i].name, "_vld"},   out_valid,    tbl[i].vld);
         chk({tbl[i].name, "_conf"},  bus_conflict, tbl[i].conf);
      end

      // A=33, PC=9: async reset between edges clears everything at once.
      control_lines = M_EP;
      #1 chk("pre_rst_pc", bus_out, 8'h09);
      control_lines = M_EA;
      #1 chk("pre_rst_a", bus_out, 8'h33);
      rst = 1'b0;
      #1;
      chk("async_a",     bus_out,      8'h00);
      control_lines = M_EP;
      #1;
      chk("async_pc",    bus_out,      8'h00);
      chk("async_flags", flag_lines,   2'b00);
      chk("async_conf",  bus_conflict, 1'b0);
      chk("async_ir",    reg_ir,       4'h0);
      chk("async_out",   out_port,     8'h00);
      control_lines = '0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      // Memory survives reset; EM with a same-cycle program write sees old data.
      cycle(M_EP|M_LM, 1'b0, 4'd0, 8'd0, b);
      chk("post_rst_mar0", b, 8'h00);
      cycle(M_EM, 1'b1, 4'd0, 8'h77, b);
      chk("mem0_kept_rbw", b, 8'h1A);
      cycle(M_EM, 1'b0, 4'd0, 8'd0, b);
      chk("mem0_written", b, 8'h77);
      cycle(M_EI|M_LM, 1'b0, 4'd0, 8'd0, b);
      cycle(M_EM, 1'b0, 4'd0, 8'd0, b);
      chk("mem10_ir0_addr0", b, 8'h77);

      // Randomized run against the behavioural model, reset every block.
      for (int blk = 0; blk < 6; blk++) begin
         async_reset();
         model_reset();
         for (int a = 0; a < 16; a++) begin
            pd = 8'($urandom);
            if (blk == 1 && a < 4) pd = 8'h80;
            prog(4'(a), pd);
            m_mem[a] = pd;
         end
         for (int n = 0; n < 60; n++) begin
            cw  = 15'($urandom & $urandom & $urandom);
            pwe = ($urandom_range(0, 7) == 0);
            pa  = 4'($urandom);
            pd  = 8'($urandom);
            cycle(cw, pwe, pa, pd, b);
            chk("rnd_bus", b, 32'(model_bus(cw)));
            model_edge(cw, pwe, pa, pd);
            chk("rnd_ir",    reg_ir,       32'(m_ir / 16));
            chk("rnd_flags", flag_lines,   32'(m_zero * 2 + m_carry));
            chk("rnd_out",   out_port,     32'(m_out));
            chk("rnd_vld",   out_valid,    32'(m_vld));
            chk("rnd_conf",  bus_conflict, 32'(m_conf));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sap_datapath.md
Name: sap_datapath

Overview:
- Execution end of the SAP control interface. Consumes the 15-bit control word from the sequencer each cycle and holds all architectural state.
- Architectural state: PC, MAR, 16x8 memory, IR, registers A/B/C/D, adder, flags and output register.
- Drives the shared 8-bit bus, and returns the opcode (reg_ir) and flags (flag_lines) to the sequencer.

Parameters:
- DATA_W, 8, bus/register width (only 8 supported).
- ADDR_W, 4, PC/MAR width; memory depth 2**ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- control_lines  in  15  bit0 EP, 1 LM, 2 C, 3 LI, 4 EM, 5 LA, 6 LB, 7 LC, 8 LD, 9 EA, 10 EB, 11 ES, 12 LO, 13 EI, 14 LP.
- bus_out  out  8  current bus value (feeds sequencer bus_in).
- reg_ir  out  4  IR[7:4], the opcode.
- flag_lines  out  2  [0] carry, [1] zero.
- out_port  out  8  output register.
- out_valid  out  1  one-cycle pulse after an LO load.
- bus_conflict  out  1  sticky error flag.
- prog_we  in  1  program-load write enable.
- prog_addr  in  4  program-load address.
- prog_data  in  8  program-load data.

Behaviour:
- Reset (rst=0, async): PC, MAR, IR, A, B, C, D, out_port, flags, out_valid and bus_conflict all clear to 0. Memory contents are not reset.
- Bus (combinational), priority EP > EM > EI > EA > EB > ES; 0 when no enable is set:
  - EP: {4'b0, PC}.
  - EM: mem[MAR].
  - EI: {4'b0, IR[3:0]}.
  - EA: A; EB: B.
  - ES: sum[7:0].
- Adder: sum = A + B, 9 bits; carry = sum[8]; wraps mod 256.
- All loads occur on the rising edge using the bus value of that cycle. Load latency is 1 clock after the control word is presented.
  - LM: MAR <= bus[3:0].
  - LI: IR <= bus.
  - LA/LB/LC/LD: the named register <= bus.
  - LO: out_port <= bus and out_valid <= 1 for exactly one cycle; otherwise out_valid <= 0.
- PC update:
  - LP: PC <= bus[3:0].
  - else C: PC <= PC+1, wrapping 15 -> 0.
  - LP and C together: LP wins.
- Flags update only when LA and ES are both set: carry <= sum[8], zero <= (sum[7:0]==0). Otherwise flags hold.
- Self-reference: EA with LA (or EB with LB) reloads the same value; no hazard.
- ES with LA: A gets the sum computed from pre-edge A and B.
- Multiple bus enables in one cycle: priority winner drives the bus and bus_conflict <= 1. It stays 1 until reset.
- Program load: prog_we writes mem[prog_addr] <= prog_data at the edge.
  - EM in the same cycle reads the old data (read-before-write).
  - prog_we is legal only while the sequencer is held in reset; the datapath does not enforce this.
- Reset mid-operation: registers clear immediately and asynchronously; bus_out falls to 0 once control_lines are 0.
- reg_ir and flag_lines are direct register outputs, with no extra latency.

Test Plan:
- Preload mem[0]=8'h1A. Cycle 1 EP|LM, cycle 2 C|LI|EM -> MAR=0, IR=8'h1A, reg_ir=4'h1, PC=1.
- Cycle 3 LA|EI with IR=8'h1A -> A=8'h0A. Then LB|EA -> B=8'h0A. Then LA|ES -> A=8'h14, carry=0, zero=0.
- A=8'hF0, B=8'h10, LA|ES -> A=8'h00, flag_lines=2'b11. A following LB|EA leaves flags at 2'b11.
- EA|LO with A=8'h55 -> out_port=8'h55; out_valid high exactly one cycle. Idle control -> out_valid=0, out_port holds 8'h55.
- PC=15, C -> PC=0. IR=8'hE7, EI|LP|C -> PC=7 (LP wins). EP|EA same cycle -> bus_out={4'b0,PC}, bus_conflict=1 and stays 1 until rst.
- A=8'h33, PC=9: assert rst=0 between clock edges -> A=0, PC=0, flags=0 immediately. Memory contents are unchanged after release.
